// File: rtl/seven_seg_pkg.sv
// Shared encodings and the hex-to-segment table for the seven-segment scan driver.
package seven_seg_pkg;

    typedef enum logic {
        GAP  = 1'b0,
        SHOW = 1'b1
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Active-low {g,f,e,d,c,b,a} patterns, entry 0 is the rightmost element.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/seven_seg_scan.sv
// Four-anode time-multiplexed seven-segment driver with per-frame snapshot,
// inter-digit dark gaps and optional leading-zero blanking.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int DIV     = 50000,
    parameter int GAP_CYC = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] data_in,
    input  logic        lz_blank,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp
);

    localparam int MAXC = (DIV > GAP_CYC) ? DIV : GAP_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] SHOW_LAST = CW'(DIV - 1);

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [11:0] snap_q, snap_d;
    logic        lz_q, lz_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;

    logic [3:0]  nib;
    logic        blank;
    logic [6:0]  dec_seg;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        snap_d  = snap_q;
        lz_d    = lz_q;
        case (state_q)
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    cnt_d   = '0;
                    state_d = GAP;
                    idx_d   = idx_q + 2'd1;
                    // Frame boundary: latch the next frame's digits atomically.
                    if (idx_q == 2'd3) begin
                        snap_d = data_in;
                        lz_d   = lz_blank;
                    end
                end
            end
        endcase
    end

    // Whenever the next state is SHOW, idx and snap are not changing on this
    // edge, so the slot contents can be decoded from the current registers.
    always_comb begin
        nib   = snap_q[3:0];
        blank = 1'b0;
        an_d  = AN_OFF;
        case (idx_q)
            2'd0: begin
                an_d = 4'b1110;
                nib  = snap_q[3:0];
            end
            2'd1: begin
                an_d  = 4'b1101;
                nib   = snap_q[7:4];
                blank = lz_q && (snap_q[11:4] == 8'h00);
            end
            2'd2: begin
                an_d  = 4'b1011;
                nib   = snap_q[11:8];
                blank = lz_q && (snap_q[11:8] == 4'h0);
            end
            default: begin
                an_d  = AN_OFF;
                blank = 1'b1;
            end
        endcase
        seg_d = blank ? SEG_BLANK : dec_seg;
        if (state_d != SHOW) begin
            an_d  = AN_OFF;
            seg_d = SEG_BLANK;
        end
    end

    hex_to_seg u_dec (
        .nib_i (nib),
        .seg_o (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= GAP;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            snap_q  <= 12'h000;
            lz_q    <= 1'b0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_BLANK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            lz_q    <= lz_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: per-frame expected an/seg streams are
// queued as stimulus is applied and popped one per clock as the display scans.
module tb_seven_seg_scan;

    localparam int DIV   = 4;
    localparam int GAPC  = 2;
    localparam int SLOT  = DIV + GAPC;
    localparam int FRAME = 4 * SLOT;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] data_in = 12'h000;
    logic        lz_blank = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];
    logic [11:0] cur_snap;
    logic        cur_lz;

    logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seven_seg_scan #(.DIV(DIV), .GAP_CYC(GAPC)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .lz_blank (lz_blank),
        .seg      (seg),
        .an       (an),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(logic [11:0] s, logic lz, int p);
        exp_t e;
        int slot, off;
        logic [3:0] n;
        logic bl;
        slot  = p / SLOT;
        off   = p % SLOT;
        e.an  = 4'hF;
        e.seg = 7'h7F;
        if (off >= GAPC && slot < 3) begin
            case (slot)
                0:       begin e.an = 4'b1110; n = s[3:0];  bl = 1'b0; end
                1:       begin e.an = 4'b1101; n = s[7:4];  bl = lz && (s[11:4] == 8'h00); end
                default: begin e.an = 4'b1011; n = s[11:8]; bl = lz && (s[11:8] == 4'h0); end
            endcase
            e.seg = bl ? 7'h7F : SEG_TAB[n];
        end
        return e;
    endfunction

    task automatic push_frame(input logic [11:0] s, input logic lz);
        for (int p = 0; p < FRAME; p++) q.push_back(model(s, lz, p));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        exp_t e;
        rst = 1'b1;
        data_in = 12'h000;
        lz_blank = 1'b0;
        tick();
        tick();
        n_checks++;
        if (an !== 4'hF) begin n_fail++; $display("FAIL reset_an: got %b want 1111", an); end
        n_checks++;
        if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg: got %h want 7f", seg); end
        n_checks++;
        if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b want 1", dp); end
        rst = 1'b0;
        cur_snap = 12'h000;
        cur_lz = 1'b0;
        // sample point is frame position 0 from here on
        push_frame(cur_snap, cur_lz);
        for (int p = 0; p < FRAME; p++) begin
            e = q.pop_front();
            n_checks++;
            if ({an, seg} !== {e.an, e.seg}) begin
                n_fail++;
                $display("FAIL first_frame p%0d: an=%b seg=%h want an=%b seg=%h", p, an, seg, e.an, e.seg);
            end
            if (p == 0) data_in = 12'hABC;
            tick();
        end
        cur_snap = 12'hABC;
    endtask

    task automatic test_basic;
        exp_t e;
        push_frame(cur_snap, cur_lz);
        for (int p = 0; p < FRAME; p++) begin
            e = q.pop_front();
            n_checks++;
            if ({an, seg} !== {e.an, e.seg}) begin
                n_fail++;
                $display("FAIL basic p%0d: an=%b seg=%h want an=%b seg=%h", p, an, seg, e.an, e.seg);
            end
            tick();
        end
    endtask

    task automatic test_sweep;
        exp_t e;
        logic [11:0] nxt;
        for (int v = 0; v < 17; v++) begin
            nxt = {8'h3C, 4'(v)};
            if (v < 16) data_in = nxt;
            push_frame(cur_snap, cur_lz);
            for (int p = 0; p < FRAME; p++) begin
                e = q.pop_front();
                n_checks++;
                if ({an, seg} !== {e.an, e.seg}) begin
                    n_fail++;
                    $display("FAIL sweep %h p%0d: an=%b seg=%h want an=%b seg=%h", cur_snap, p, an, seg, e.an, e.seg);
                end
                tick();
            end
            cur_snap = data_in;
        end
    endtask

    task automatic test_lz;
        exp_t e;
        logic [11:0] vals [4] = '{12'h005, 12'h050, 12'h111, 12'h111};
        logic        lzs  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int f = 0; f < 4; f++) begin
            data_in  = vals[f];
            lz_blank = lzs[f];
            push_frame(cur_snap, cur_lz);
            for (int p = 0; p < FRAME; p++) begin
                e = q.pop_front();
                n_checks++;
                if ({an, seg} !== {e.an, e.seg}) begin
                    n_fail++;
                    $display("FAIL lz %h/%b p%0d: an=%b seg=%h want an=%b seg=%h", cur_snap, cur_lz, p, an, seg, e.an, e.seg);
                end
                tick();
            end
            cur_snap = vals[f];
            cur_lz   = lzs[f];
        end
    endtask

    task automatic test_midframe;
        exp_t e;
        push_frame(cur_snap, cur_lz);
        push_frame(12'h222, 1'b0);
        for (int p = 0; p < 2 * FRAME; p++) begin
            e = q.pop_front();
            n_checks++;
            if ({an, seg} !== {e.an, e.seg}) begin
                n_fail++;
                $display("FAIL midframe p%0d: an=%b seg=%h want an=%b seg=%h", p, an, seg, e.an, e.seg);
            end
            if (p == SLOT + GAPC + 1) data_in = 12'h222;
            tick();
        end
        cur_snap = 12'h222;
    endtask

    task automatic test_reset_mid;
        exp_t e;
        data_in = 12'h333;
        push_frame(cur_snap, cur_lz);
        for (int p = 0; p <= 2 * SLOT + GAPC + 1; p++) begin
            e = q.pop_front();
            n_checks++;
            if ({an, seg} !== {e.an, e.seg}) begin
                n_fail++;
                $display("FAIL pre_reset p%0d: an=%b seg=%h want an=%b seg=%h", p, an, seg, e.an, e.seg);
            end
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        push_frame(12'h000, 1'b0);
        push_frame(12'h333, 1'b0);
        for (int p = 0; p < 2 * FRAME; p++) begin
            e = q.pop_front();
            n_checks++;
            if ({an, seg} !== {e.an, e.seg}) begin
                n_fail++;
                $display("FAIL post_reset p%0d: an=%b seg=%h want an=%b seg=%h", p, an, seg, e.an, e.seg);
            end
            tick();
        end
        cur_snap = 12'h333;
    endtask

    task automatic test_random;
        logic [3:0] prev_an;
        int run_len, runs, want;
        prev_an = an;
        run_len = 0;
        runs = 0;
        for (int c = 0; c < 1000; c++) begin
            n_checks++;
            if ($countones(~an) > 1) begin n_fail++; $display("FAIL onehot c%0d: an=%b want at most one low", c, an); end
            n_checks++;
            if (dp !== 1'b1) begin n_fail++; $display("FAIL dp c%0d: got %b want 1", c, dp); end
            if (an != prev_an) begin
                if (runs > 0) begin
                    if (prev_an == 4'hF) want = (an == 4'b1110) ? (2 * GAPC + DIV) : GAPC;
                    else want = DIV;
                    n_checks++;
                    if (run_len != want) begin
                        n_fail++;
                        $display("FAIL run_len an=%b: got %0d cycles want %0d", prev_an, run_len, want);
                    end
                end
                runs++;
                run_len = 0;
                prev_an = an;
            end
            run_len++;
            if ($urandom_range(0, 3) == 0) begin
                data_in  = 12'($urandom);
                lz_blank = 1'($urandom);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sweep();
        test_lz();
        test_midframe();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
